// File: rtl/core_debug_pkg.sv
// Shared definitions for the core debug unit: command codes, FSM states and the
// breakpoint entry type used by the top and the comparator bank.
package core_debug_pkg;

    localparam int P_DATA_W_DEF  = 32;
    localparam int P_BRK_NUM_DEF = 4;
    localparam int P_TMO_W_DEF   = 8;

    // Entries carry a fixed-width address so one typedef serves any P_DATA_W up to 64;
    // narrower PCs are zero-extended and the constant upper bits fall away in synthesis.
    localparam int BRK_ADDR_W = 64;

    typedef enum logic [3:0] {
        CMD_RD_REG  = 4'h0,
        CMD_WR_REG  = 4'h1,
        CMD_SET_BRK = 4'h2,
        CMD_CLR_BRK = 4'h3,
        CMD_GO      = 4'h8,
        CMD_STEP    = 4'hA,
        CMD_STOP    = 4'hF
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CORE_WAIT = 2'd1,
        ST_REG_WAIT  = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    typedef struct packed {
        logic                  en;
        logic [BRK_ADDR_W-1:0] addr;
    } brk_entry_t;

endpackage

// File: rtl/core_debug_brk_cmp.sv
// PC breakpoint comparator bank with a lowest-index-wins priority encoder.
// Purely combinational on the registered entries held by the top.
module core_debug_brk_cmp
    import core_debug_pkg::*;
#(
    parameter int P_DATA_W  = P_DATA_W_DEF,
    parameter int P_BRK_NUM = P_BRK_NUM_DEF
) (
    input  brk_entry_t [P_BRK_NUM-1:0] brk_i,
    input  logic                       arm_i,
    input  logic                       pc_valid_i,
    input  logic [P_DATA_W-1:0]        pc_i,
    output logic                       hit_o,
    output logic [3:0]                 idx_o
);

    logic [BRK_ADDR_W-1:0] pc_ext;
    logic [P_BRK_NUM-1:0]  match;

    assign pc_ext = BRK_ADDR_W'(pc_i);

    for (genvar g = 0; g < P_BRK_NUM; g++) begin : g_cmp
        assign match[g] = brk_i[g].en && (brk_i[g].addr == pc_ext);
    end

    always_comb begin
        hit_o = arm_i && pc_valid_i && (|match);
        idx_o = '0;
        for (int i = P_BRK_NUM - 1; i >= 0; i--) begin
            if (match[i]) idx_o = 4'(i);
        end
    end

endmodule

// File: rtl/core_debug_unit.sv
// Debug controller between the external command link and one core: run control
// handshakes, register access over request/ack, and PC breakpoints with auto-stop.
module core_debug_unit
    import core_debug_pkg::*;
#(
    parameter int P_DATA_W  = P_DATA_W_DEF,
    parameter int P_BRK_NUM = P_BRK_NUM_DEF,
    parameter int P_TMO_W   = P_TMO_W_DEF
) (
    input  logic                iCLOCK,
    input  logic                iRESET_SYNC,
    input  logic                iCMD_REQ,
    output logic                oCMD_BUSY,
    input  logic [3:0]          iCMD_COMMAND,
    input  logic [7:0]          iCMD_TARGET,
    input  logic [P_DATA_W-1:0] iCMD_DATA,
    output logic                oRESP_VALID,
    output logic                oRESP_ERROR,
    output logic [P_DATA_W-1:0] oRESP_DATA,
    output logic                oDEBUG_CORE_REQ,
    output logic                oDEBUG_CORE_STOP,
    output logic                oDEBUG_CORE_START,
    output logic                oDEBUG_CORE_STEP,
    input  logic                iDEBUG_CORE_ACK,
    output logic                oREG_REQ,
    output logic                oREG_RW,
    output logic [7:0]          oREG_ADDR,
    output logic [P_DATA_W-1:0] oREG_WDATA,
    input  logic                iREG_ACK,
    input  logic                iREG_NOEXIST,
    input  logic [P_DATA_W-1:0] iREG_RDATA,
    input  logic                iPC_VALID,
    input  logic [P_DATA_W-1:0] iPC,
    output logic                oCORE_STOPPED,
    output logic                oBRK_EVENT,
    output logic [3:0]          oBRK_IDX
);

    state_e                     state_q;
    logic [P_TMO_W-1:0]         tmo_q, tmo_d;
    logic                       tmo_expire;
    brk_entry_t [P_BRK_NUM-1:0] brk_q;
    logic                       pend_q, brk_op_q, stopped_q, brk_evt_q;
    logic [3:0]                 pend_idx_q, brk_idx_q;
    logic                       core_req_q, core_stop_q, core_start_q, core_step_q;
    logic                       reg_req_q, reg_rw_q, resp_err_q;
    logic [7:0]                 reg_addr_q;
    logic [P_DATA_W-1:0]        reg_wdata_q, resp_data_q;
    logic                       hit, arm, idx_bad;
    logic [3:0]                 hit_idx, cmd_idx;

    assign tmo_d      = tmo_q + P_TMO_W'(1);
    assign tmo_expire = &tmo_d;
    // Masking during CORE_WAIT keeps a STEP from re-hitting the PC it just executed.
    assign arm        = (state_q != ST_CORE_WAIT) && !stopped_q;
    assign cmd_idx    = iCMD_TARGET[3:0];
    assign idx_bad    = {28'd0, cmd_idx} >= 32'(P_BRK_NUM);

    core_debug_brk_cmp #(
        .P_DATA_W  (P_DATA_W),
        .P_BRK_NUM (P_BRK_NUM)
    ) u_brk_cmp (
        .brk_i      (brk_q),
        .arm_i      (arm),
        .pc_valid_i (iPC_VALID),
        .pc_i       (iPC),
        .hit_o      (hit),
        .idx_o      (hit_idx)
    );

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            brk_q        <= '0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            brk_op_q     <= 1'b0;
            stopped_q    <= 1'b0;
            brk_evt_q    <= 1'b0;
            brk_idx_q    <= '0;
            core_req_q   <= 1'b0;
            core_stop_q  <= 1'b0;
            core_start_q <= 1'b0;
            core_step_q  <= 1'b0;
            reg_req_q    <= 1'b0;
            reg_rw_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            brk_evt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A remembered or fresh hit is serviced ahead of any command.
                    if (pend_q || hit) begin
                        pend_q      <= 1'b0;
                        pend_idx_q  <= pend_q ? pend_idx_q : hit_idx;
                        brk_op_q    <= 1'b1;
                        core_req_q  <= 1'b1;
                        core_stop_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= ST_CORE_WAIT;
                    end else if (iCMD_REQ) begin
                        brk_op_q    <= 1'b0;
                        resp_err_q  <= 1'b0;
                        resp_data_q <= '0;
                        state_q     <= ST_RESP;
                        case (iCMD_COMMAND)
                            CMD_SET_BRK, CMD_CLR_BRK: begin
                                if (idx_bad) begin
                                    resp_err_q <= 1'b1;
                                end else begin
                                    for (int i = 0; i < P_BRK_NUM; i++) begin
                                        if (cmd_idx == 4'(i)) begin
                                            brk_q[i].en <= (iCMD_COMMAND == CMD_SET_BRK);
                                            if (iCMD_COMMAND == CMD_SET_BRK)
                                                brk_q[i].addr <= BRK_ADDR_W'(iCMD_DATA);
                                        end
                                    end
                                end
                            end
                            CMD_RD_REG, CMD_WR_REG: begin
                                if (!stopped_q) begin
                                    resp_err_q <= 1'b1;
                                end else begin
                                    reg_req_q   <= 1'b1;
                                    reg_rw_q    <= (iCMD_COMMAND == CMD_WR_REG);
                                    reg_addr_q  <= iCMD_TARGET;
                                    reg_wdata_q <= iCMD_DATA;
                                    tmo_q       <= '0;
                                    state_q     <= ST_REG_WAIT;
                                end
                            end
                            CMD_GO, CMD_STEP: begin
                                if (!stopped_q) begin
                                    resp_err_q <= 1'b1;
                                end else begin
                                    core_req_q   <= 1'b1;
                                    core_start_q <= (iCMD_COMMAND == CMD_GO);
                                    core_step_q  <= (iCMD_COMMAND == CMD_STEP);
                                    tmo_q        <= '0;
                                    state_q      <= ST_CORE_WAIT;
                                end
                            end
                            CMD_STOP: begin
                                if (!stopped_q) begin
                                    core_req_q  <= 1'b1;
                                    core_stop_q <= 1'b1;
                                    tmo_q       <= '0;
                                    state_q     <= ST_CORE_WAIT;
                                end
                            end
                            default: resp_err_q <= 1'b1;
                        endcase
                    end
                end
                ST_CORE_WAIT: begin
                    if (iDEBUG_CORE_ACK || tmo_expire) begin
                        core_req_q   <= 1'b0;
                        core_stop_q  <= 1'b0;
                        core_start_q <= 1'b0;
                        core_step_q  <= 1'b0;
                        if (iDEBUG_CORE_ACK) stopped_q <= !core_start_q;
                        if (brk_op_q) begin
                            brk_evt_q <= iDEBUG_CORE_ACK;
                            if (iDEBUG_CORE_ACK) brk_idx_q <= pend_idx_q;
                            state_q <= ST_IDLE;
                        end else begin
                            resp_err_q <= !iDEBUG_CORE_ACK;
                            state_q    <= ST_RESP;
                        end
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                ST_REG_WAIT: begin
                    if (iREG_ACK || tmo_expire) begin
                        reg_req_q  <= 1'b0;
                        resp_err_q <= !iREG_ACK || iREG_NOEXIST;
                        if (iREG_ACK && !reg_rw_q) resp_data_q <= iREG_RDATA;
                        state_q <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                    if (hit && !pend_q) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= hit_idx;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (hit && !pend_q) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= hit_idx;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oCMD_BUSY         = (state_q != ST_IDLE);
    assign oRESP_VALID       = (state_q == ST_RESP);
    assign oRESP_ERROR       = oRESP_VALID && resp_err_q;
    assign oRESP_DATA        = resp_data_q;
    assign oDEBUG_CORE_REQ   = core_req_q;
    assign oDEBUG_CORE_STOP  = core_stop_q;
    assign oDEBUG_CORE_START = core_start_q;
    assign oDEBUG_CORE_STEP  = core_step_q;
    assign oREG_REQ          = reg_req_q;
    assign oREG_RW           = reg_rw_q;
    assign oREG_ADDR         = reg_addr_q;
    assign oREG_WDATA        = reg_wdata_q;
    assign oCORE_STOPPED     = stopped_q;
    assign oBRK_EVENT        = brk_evt_q;
    assign oBRK_IDX          = brk_idx_q;

endmodule

// File: tb/tb_core_debug_unit.sv
// Directed bench for core_debug_unit: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them; small core/register responders ack requests.
module tb_core_debug_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_req = 1'b0;
    logic        busy;
    logic [3:0]  cmd = '0;
    logic [7:0]  tgt = '0;
    logic [31:0] cdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        core_req, core_stop, core_start, core_step;
    logic        core_ack = 1'b0;
    logic        reg_req, reg_rw;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack = 1'b0, reg_noexist = 1'b0;
    logic [31:0] reg_rdata = '0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        stopped, brk_evt;
    logic [3:0]  brk_idx;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    int core_dly = 1, reg_dly = 1;
    logic [31:0] rd_val = '0;
    logic        rd_noexist = 1'b0;
    int core_req_cyc = 0, reg_req_cyc = 0, brk_evt_cnt = 0;
    logic [2:0]  core_type = '0;
    logic        rw_seen = 1'b0;
    logic [7:0]  addr_seen = '0;
    logic [31:0] wdata_seen = '0;

    core_debug_unit #(.P_DATA_W(32), .P_BRK_NUM(4), .P_TMO_W(8)) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst),
        .iCMD_REQ(cmd_req), .oCMD_BUSY(busy), .iCMD_COMMAND(cmd), .iCMD_TARGET(tgt),
        .iCMD_DATA(cdata), .oRESP_VALID(resp_valid), .oRESP_ERROR(resp_err),
        .oRESP_DATA(resp_data), .oDEBUG_CORE_REQ(core_req), .oDEBUG_CORE_STOP(core_stop),
        .oDEBUG_CORE_START(core_start), .oDEBUG_CORE_STEP(core_step),
        .iDEBUG_CORE_ACK(core_ack), .oREG_REQ(reg_req), .oREG_RW(reg_rw),
        .oREG_ADDR(reg_addr), .oREG_WDATA(reg_wdata), .iREG_ACK(reg_ack),
        .iREG_NOEXIST(reg_noexist), .iREG_RDATA(reg_rdata), .iPC_VALID(pc_valid),
        .iPC(pc), .oCORE_STOPPED(stopped), .oBRK_EVENT(brk_evt), .oBRK_IDX(brk_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Core and register responders: ack on the Nth cycle a request is seen (0 = never).
    initial begin
        int ccnt, rcnt;
        ccnt = 0; rcnt = 0;
        forever begin
            @(negedge clk);
            if (core_req) begin
                ccnt++;
                core_ack = (core_dly != 0) && (ccnt == core_dly);
            end else begin
                ccnt = 0;
                core_ack = 1'b0;
            end
            if (reg_req) begin
                rcnt++;
                reg_ack = (reg_dly != 0) && (rcnt == reg_dly);
            end else begin
                rcnt = 0;
                reg_ack = 1'b0;
            end
            reg_noexist = reg_ack && rd_noexist;
            reg_rdata   = reg_ack ? rd_val : 32'h0;
        end
    end

    // Monitor: request bookkeeping plus scoreboard compare on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (core_req) begin
                core_req_cyc++;
                core_type = {core_stop, core_start, core_step};
            end
            if (reg_req) begin
                reg_req_cyc++;
                rw_seen    = reg_rw;
                addr_seen  = reg_addr;
                wdata_seen = reg_wdata;
            end
            if (brk_evt) brk_evt_cnt++;
            if (core_req && reg_req) begin
                n_fail++;
                $display("FAIL dual_req: core and register requests both high");
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got err=%0b data=0x%0h, expected no response",
                             resp_err, resp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
                    chk("resp_data", {32'd0, resp_data}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [7:0] t, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_data, input bit has_resp);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("busy_timeout", 64'd1, 64'd0);
        cmd = c; tgt = t; cdata = d; cmd_req = 1'b1;
        if (has_resp) exp_q.push_back('{exp_err, exp_data});
        @(negedge clk);
        cmd_req = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || busy) chk("resp_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    function automatic logic any_out();
        return |{busy, resp_valid, resp_err, resp_data, core_req, core_stop, core_start,
                 core_step, reg_req, reg_rw, reg_addr, reg_wdata, stopped, brk_evt, brk_idx};
    endfunction

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {63'd0, any_out()}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // STOP, ack after 3 cycles
        core_dly = 3; core_req_cyc = 0;
        send(4'hF, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("stop_req_cycles", 64'(core_req_cyc), 64'd3);
        chk("stop_type", {61'd0, core_type}, 64'b100);
        chk("stopped_after_stop", {63'd0, stopped}, 64'd1);

        // STOP while stopped: immediate OK, no core request
        core_req_cyc = 0;
        send(4'hF, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("stop_again_no_req", 64'(core_req_cyc), 64'd0);

        // Register read, ack at +2
        reg_dly = 2; rd_val = 32'h0000_1000; rd_noexist = 1'b0; reg_req_cyc = 0;
        send(4'h0, 8'h43, 32'h0, 1'b0, 32'h0000_1000, 1'b1);
        wait_done();
        chk("rd_req_cycles", 64'(reg_req_cyc), 64'd2);
        chk("rd_addr", {56'd0, addr_seen}, 64'h43);
        chk("rd_rw", {63'd0, rw_seen}, 64'd0);

        // Nonexistent register
        rd_val = 32'h0; rd_noexist = 1'b1;
        send(4'h0, 8'h50, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_done();
        rd_noexist = 1'b0;

        // Register write
        send(4'h1, 8'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("wr_rw", {63'd0, rw_seen}, 64'd1);
        chk("wr_wdata", {32'd0, wdata_seen}, 64'hDEAD_BEEF);

        // GO -> running
        core_dly = 1; core_req_cyc = 0;
        send(4'h8, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        chk("go_type", {61'd0, core_type}, 64'b010);
        chk("running_after_go", {63'd0, stopped}, 64'd0);

        // Errors while running / bad index / unknown code
        reg_req_cyc = 0;
        send(4'h1, 8'h10, 32'h1234, 1'b1, 32'h0, 1'b1);
        wait_done();
        chk("wr_running_no_req", 64'(reg_req_cyc), 64'd0);
        send(4'h2, 8'h07, 32'h0000_0300, 1'b1, 32'h0, 1'b1);
        send(4'h5, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1);
        core_req_cyc = 0;
        send(4'h8, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_done();
        chk("go_running_no_req", 64'(core_req_cyc), 64'd0);

        // Breakpoints 0,1,3 at 0x200, then clear 0: idx 1 must win
        send(4'h2, 8'h00, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
        send(4'h2, 8'h01, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
        send(4'h2, 8'h03, 32'h0000_0200, 1'b0, 32'h0, 1'b1);
        send(4'h3, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        pc = 32'h0000_0204; pc_valid = 1'b1;
        @(negedge clk);
        chk("no_hit_other_pc", {63'd0, busy}, 64'd0);
        core_dly = 2;
        pc = 32'h0000_0200;
        @(negedge clk);
        pc_valid = 1'b0;
        k = 0;
        while (brk_evt_cnt == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("brk_event_count", 64'(brk_evt_cnt), 64'd1);
        chk("brk_stop_type", {61'd0, core_type}, 64'b100);
        chk("brk_idx", {60'd0, brk_idx}, 64'd1);
        chk("stopped_after_brk", {63'd0, stopped}, 64'd1);
        wait_done();

        // STEP at the breakpoint PC: no re-hit
        core_dly = 3;
        pc = 32'h0000_0200; pc_valid = 1'b1;
        send(4'hA, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1);
        wait_done();
        pc_valid = 1'b0;
        chk("step_type", {61'd0, core_type}, 64'b001);
        chk("stopped_after_step", {63'd0, stopped}, 64'd1);
        chk("step_no_rehit", 64'(brk_evt_cnt), 64'd1);
        chk("brk_idx_held", {60'd0, brk_idx}, 64'd1);

        // GO with no ack: timeout
        core_dly = 0; core_req_cyc = 0;
        send(4'h8, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1);
        wait_done();
        chk("timeout_req_cycles", 64'(core_req_cyc), 64'd255);
        chk("stopped_after_timeout", {63'd0, stopped}, 64'd1);

        // Reset while a register read is outstanding
        reg_dly = 0;
        send(4'h0, 8'h20, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("reg_req_before_reset", {63'd0, reg_req}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("outputs_after_reset", {63'd0, any_out()}, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_pending_expect", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
